// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: control-bus fields,
// access-size and write-back-select encodings, FSM states.
package mem_pkg;

    localparam int C_REGWRITE = 0;
    localparam int C_MEMREAD  = 1;
    localparam int C_MEMWRITE = 2;
    localparam int C_SIZE_LO  = 3;
    localparam int C_UNS      = 5;
    localparam int C_WBSEL_LO = 6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_RET = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    function automatic logic [31:0] wb_mux(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] mem,
        input logic [31:0] ret,
        input logic [31:0] imm
    );
        logic [31:0] r;
        unique case (sel)
            WB_ALU:  r = alu;
            WB_MEM:  r = mem;
            WB_RET:  r = ret;
            default: r = imm;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_if.sv
// Data-memory request/acknowledge bus between the stage and memory.
interface mem_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage_load_formatter.sv
// Picks the addressed byte/half out of a read word and extends it.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] res_o
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        unique case (off_i)
            2'd0:    b = rdata_i[7:0];
            2'd1:    b = rdata_i[15:8];
            2'd2:    b = rdata_i[23:16];
            default: b = rdata_i[31:24];
        endcase
        h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (size_i)
            SZ_BYTE: res_o = {{24{b[7] & ~uns_i}}, b};
            SZ_HALF: res_o = {{16{h[15] & ~uns_i}}, h};
            default: res_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack bus, stalls
// upstream while outstanding, and registers the MEM/WB result.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clkIn,
    input  logic              reset,
    input  logic [4:0]        rdIn,
    input  logic [31:0]       ResultIn,
    input  logic [DATA_W-1:0] Data2In,
    input  logic [31:0]       retAddrIn,
    input  logic [31:0]       ImmIn,
    input  logic [11:0]       Ctrl_signalIn,
    mem_if.master             dmem,
    output logic              memStall,
    output logic [4:0]        rdOut,
    output logic [31:0]       WbDataOut,
    output logic              RegWriteOut,
    output logic              MisalignOut
);
    logic       regw, rd_en, wr_en;
    logic [1:0] sz, wbsel, off;
    logic       memop, mis;
    logic       unused_ctrl;

    assign regw  = Ctrl_signalIn[C_REGWRITE];
    assign rd_en = Ctrl_signalIn[C_MEMREAD];
    assign wr_en = Ctrl_signalIn[C_MEMWRITE];
    assign sz    = Ctrl_signalIn[C_SIZE_LO +: 2];
    assign wbsel = Ctrl_signalIn[C_WBSEL_LO +: 2];
    assign off   = ResultIn[1:0];
    assign memop = rd_en | wr_en;
    assign unused_ctrl = ^Ctrl_signalIn[11:8];

    always_comb begin
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = memop & off[0];
            default: mis = memop & (off != 2'b00);
        endcase
    end

    logic [0:0]        state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [4:0]        rdl_q, rdl_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rdwb_q, rdwb_d;
    logic [31:0]       wb_q, wb_d;
    logic              rw_q, rw_d, mis_q, mis_d;
    logic [31:0]       st_data, ld_val;
    logic [3:0]        st_strb;

    // Replicate store data across every lane it may land in.
    always_comb begin
        case (sz)
            SZ_BYTE: begin
                st_data = {4{Data2In[7:0]}};
                st_strb = 4'b0001 << off;
            end
            SZ_HALF: begin
                st_data = {2{Data2In[15:0]}};
                st_strb = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = Data2In[31:0];
                st_strb = 4'b1111;
            end
        endcase
    end

    load_formatter u_fmt (
        .rdata_i (dmem.rdata),
        .off_i   (off_q),
        .size_i  (ctrl_q[C_SIZE_LO +: 2]),
        .uns_i   (ctrl_q[C_UNS]),
        .res_o   (ld_val)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdl_d    = rdl_q;
        ctrl_d   = ctrl_q;
        off_d    = off_q;
        rdwb_d   = '0;
        rw_d     = 1'b0;
        mis_d    = 1'b0;
        wb_d     = wb_q;
        memStall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memop && !mis) begin
                    memStall = 1'b1;
                    req_d    = 1'b1;
                    we_d     = wr_en;
                    addr_d   = {ResultIn[ADDR_W-1:2], 2'b00};
                    wdata_d  = st_data;
                    wstrb_d  = wr_en ? st_strb : 4'b0000;
                    rdl_d    = rdIn;
                    ctrl_d   = Ctrl_signalIn[7:0];
                    off_d    = off;
                    state_d  = S_ACCESS;
                end else begin
                    rdwb_d = rdIn;
                    rw_d   = regw & ~mis;
                    mis_d  = mis;
                    wb_d   = wb_mux(wbsel, ResultIn, 32'h0,
                                    retAddrIn, ImmIn);
                end
            end
            S_ACCESS: begin
                if (!dmem.ack) begin
                    memStall = 1'b1;
                end else begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    rdwb_d  = rdl_q;
                    // read+write together behaves as a plain store
                    rw_d    = ctrl_q[C_REGWRITE] &
                              ~(ctrl_q[C_MEMREAD] & ctrl_q[C_MEMWRITE]);
                    wb_d    = wb_mux(ctrl_q[C_WBSEL_LO +: 2], ResultIn,
                                     ld_val, retAddrIn, ImmIn);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdl_q   <= '0;
            ctrl_q  <= '0;
            off_q   <= '0;
            rdwb_q  <= '0;
            wb_q    <= '0;
            rw_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdl_q   <= rdl_d;
            ctrl_q  <= ctrl_d;
            off_q   <= off_d;
            rdwb_q  <= rdwb_d;
            wb_q    <= wb_d;
            rw_q    <= rw_d;
            mis_q   <= mis_d;
        end
    end

    assign dmem.req    = req_q;
    assign dmem.we     = we_q;
    assign dmem.addr   = addr_q;
    assign dmem.wdata  = wdata_q;
    assign dmem.wstrb  = wstrb_q;
    assign rdOut       = rdwb_q;
    assign WbDataOut   = wb_q;
    assign RegWriteOut = rw_q;
    assign MisalignOut = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mem_stage;

    logic        clkIn = 1'b0;
    logic        reset;
    logic [4:0]  rdIn;
    logic [31:0] ResultIn, Data2In, retAddrIn, ImmIn;
    logic [11:0] Ctrl_signalIn;
    logic        memStall;
    logic [4:0]  rdOut;
    logic [31:0] WbDataOut;
    logic        RegWriteOut, MisalignOut;

    int checks = 0;
    int errors = 0;

    mem_if #(.ADDR_W(32)) dmem ();

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clkIn         (clkIn),
        .reset         (reset),
        .rdIn          (rdIn),
        .ResultIn      (ResultIn),
        .Data2In       (Data2In),
        .retAddrIn     (retAddrIn),
        .ImmIn         (ImmIn),
        .Ctrl_signalIn (Ctrl_signalIn),
        .dmem          (dmem),
        .memStall      (memStall),
        .rdOut         (rdOut),
        .WbDataOut     (WbDataOut),
        .RegWriteOut   (RegWriteOut),
        .MisalignOut   (MisalignOut)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        int          cycles;
        int          stalls;
        int          reqs;
        bit          stable;
        bit          timeout;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        req_after;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic        rw;
        logic        mis;
    } obs_t;

    // Drives one EX/MEM entry, answers the bus after `ackwait` request
    // cycles, and records what the stage did until it stops stalling.
    task automatic run_op(
        input  logic [11:0] ctrl,
        input  logic [4:0]  rd,
        input  logic [31:0] res,
        input  logic [31:0] d2,
        input  logic [31:0] ret,
        input  logic [31:0] imm,
        input  logic [31:0] rdata,
        input  int          ackwait,
        output obs_t        o
    );
        int reqn;
        bit done;
        o = '{default: 0};
        o.stable = 1'b1;
        Ctrl_signalIn = ctrl;
        rdIn = rd;
        ResultIn = res;
        Data2In = d2;
        retAddrIn = ret;
        ImmIn = imm;
        reqn = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (dmem.req && reqn == ackwait) begin
                dmem.ack = 1'b1;
                dmem.rdata = rdata;
            end else begin
                dmem.ack = 1'b0;
                dmem.rdata = $urandom;
            end
            #1;
            if (memStall) o.stalls++;
            if (dmem.req) begin
                if (reqn == 0) begin
                    o.we = dmem.we;
                    o.addr = dmem.addr;
                    o.wdata = dmem.wdata;
                    o.wstrb = dmem.wstrb;
                end else if (dmem.we !== o.we || dmem.addr !== o.addr ||
                             dmem.wdata !== o.wdata ||
                             dmem.wstrb !== o.wstrb) begin
                    o.stable = 1'b0;
                end
                reqn++;
            end
            done = !memStall;
            @(posedge clkIn);
            #1;
            o.cycles++;
        end
        o.reqs = reqn;
        o.timeout = !done;
        dmem.ack = 1'b0;
        o.req_after = dmem.req;
        o.rd = rdOut;
        o.wb = WbDataOut;
        o.rw = RegWriteOut;
        o.mis = MisalignOut;
    endtask

    function automatic logic [31:0] ref_load(
        input logic [31:0] word, input int off, input int size, input bit uns
    );
        logic [31:0] v;
        if (size == 0) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (word >> (8 * (off & 2))) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        rdIn = 5'd7;
        ResultIn = 32'h100;
        Data2In = 32'h55;
        retAddrIn = 0;
        ImmIn = 0;
        Ctrl_signalIn = 12'h053;
        dmem.ack = 1'b0;
        dmem.rdata = 0;
        repeat (2) @(posedge clkIn);
        #1;
        checks++;
        if ({dmem.req, dmem.we, dmem.wstrb} !== 6'b0) begin
            errors++;
            $display("FAIL reset_req got %b want 0",
                     {dmem.req, dmem.we, dmem.wstrb});
        end
        checks++;
        if ({dmem.addr, dmem.wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus got %h want 0",
                     {dmem.addr, dmem.wdata});
        end
        checks++;
        if ({rdOut, WbDataOut, RegWriteOut, MisalignOut} !== 39'h0) begin
            errors++;
            $display("FAIL reset_wb got %h want 0",
                     {rdOut, WbDataOut, RegWriteOut, MisalignOut});
        end
        Ctrl_signalIn = 12'h000;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        obs_t o;
        run_op(12'h001, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 0, o);
        checks++;
        if ({o.rd, o.wb, o.rw} !== {5'd5, 32'h1234, 1'b1}) begin
            errors++;
            $display("FAIL alu_wb got rd=%0d wb=%h rw=%b want 5 1234 1",
                     o.rd, o.wb, o.rw);
        end
        checks++;
        if (o.stalls !== 0 || o.cycles !== 1) begin
            errors++;
            $display("FAIL alu_timing got stalls=%0d cyc=%0d want 0 1",
                     o.stalls, o.cycles);
        end
    endtask

    task automatic test_lw();
        obs_t o;
        run_op(12'h053, 5'd9, 32'h100, 32'h0, 32'h0, 32'h0,
               32'hDEAD_BEEF, 0, o);
        checks++;
        if ({o.addr, o.wstrb, o.we} !== {32'h100, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL lw_req got addr=%h strb=%b we=%b want 100 0 0",
                     o.addr, o.wstrb, o.we);
        end
        checks++;
        if ({o.rd, o.wb, o.rw} !== {5'd9, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL lw_wb got rd=%0d wb=%h rw=%b want 9 deadbeef 1",
                     o.rd, o.wb, o.rw);
        end
        checks++;
        if (o.cycles !== 2 || o.stalls !== 1 || o.req_after !== 1'b0 ||
            o.timeout) begin
            errors++;
            $display("FAIL lw_timing got cyc=%0d stall=%0d req=%b want 2 1 0",
                     o.cycles, o.stalls, o.req_after);
        end
    endtask

    task automatic test_lb();
        obs_t o;
        run_op(12'h043, 5'd3, 32'h103, 32'h0, 32'h0, 32'h0,
               32'h80FF_0000, 1, o);
        checks++;
        if (o.wb !== 32'hFFFF_FF80 || o.addr !== 32'h100) begin
            errors++;
            $display("FAIL lb got wb=%h addr=%h want ffffff80 100",
                     o.wb, o.addr);
        end
        run_op(12'h063, 5'd3, 32'h103, 32'h0, 32'h0, 32'h0,
               32'h80FF_0000, 0, o);
        checks++;
        if (o.wb !== 32'h0000_0080 || o.rw !== 1'b1) begin
            errors++;
            $display("FAIL lbu got wb=%h rw=%b want 00000080 1",
                     o.wb, o.rw);
        end
    endtask

    task automatic test_sh();
        obs_t o;
        run_op(12'h00C, 5'd4, 32'h102, 32'h0000_ABCD, 32'h0, 32'h0,
               32'h0, 3, o);
        checks++;
        if ({o.wdata, o.wstrb, o.we} !== {32'hABCD_ABCD, 4'b1100, 1'b1}) begin
            errors++;
            $display("FAIL sh_lanes got wd=%h strb=%b we=%b want abcdabcd 1100 1",
                     o.wdata, o.wstrb, o.we);
        end
        checks++;
        if (o.reqs !== 4 || !o.stable || o.cycles !== 5) begin
            errors++;
            $display("FAIL sh_hold got reqs=%0d stable=%b cyc=%0d want 4 1 5",
                     o.reqs, o.stable, o.cycles);
        end
        checks++;
        if (o.rw !== 1'b0 || o.req_after !== 1'b0) begin
            errors++;
            $display("FAIL sh_wb got rw=%b req=%b want 0 0",
                     o.rw, o.req_after);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        run_op(12'h053, 5'd8, 32'h101, 32'h0, 32'h0, 32'h0, 32'h0, 0, o);
        checks++;
        if (o.reqs !== 0 || o.stalls !== 0 || o.cycles !== 1) begin
            errors++;
            $display("FAIL mis_timing got reqs=%0d stall=%0d cyc=%0d want 0 0 1",
                     o.reqs, o.stalls, o.cycles);
        end
        checks++;
        if (o.mis !== 1'b1 || o.rw !== 1'b0) begin
            errors++;
            $display("FAIL mis_flags got mis=%b rw=%b want 1 0", o.mis, o.rw);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        Ctrl_signalIn = 12'h053;
        rdIn = 5'd12;
        ResultIn = 32'h200;
        dmem.ack = 1'b0;
        repeat (2) begin
            @(posedge clkIn);
            #1;
        end
        checks++;
        if (dmem.req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got req=%b want 1", dmem.req);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dmem.req !== 1'b0 ||
            {rdOut, WbDataOut, RegWriteOut, MisalignOut} !== 39'h0) begin
            errors++;
            $display("FAIL rstmid got req=%b wb=%h want 0 0", dmem.req,
                     {rdOut, WbDataOut, RegWriteOut, MisalignOut});
        end
        #1;
        reset = 1'b0;
        run_op(12'h081, 5'd6, 32'h0, 32'h0, 32'hCAFE_0004, 32'h0, 32'h0, 0, o);
        checks++;
        if (o.cycles !== 1 || o.stalls !== 0 || o.wb !== 32'hCAFE_0004 ||
            o.rd !== 5'd6) begin
            errors++;
            $display("FAIL rstmid_idle got cyc=%0d wb=%h rd=%0d want 1 cafe0004 6",
                     o.cycles, o.wb, o.rd);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int n = 0; n < 80; n++) begin
            bit regw, mr, mw, uns, memop, mis, aligned, exp_rw;
            int size, wsel, off, aw, exp_cyc;
            logic [31:0] res, d2, ret, imm, rdata, exp_wb, exp_wd;
            logic [3:0]  exp_strb;
            logic [4:0]  rd;
            logic [11:0] ctrl;
            regw = 1'($urandom);
            mr = 1'($urandom);
            mw = 1'($urandom);
            uns = 1'($urandom);
            size = $urandom_range(0, 2);
            if (mr && !mw) wsel = 1;
            else begin
                wsel = $urandom_range(0, 2);
                if (wsel != 0) wsel++;
            end
            res = $urandom;
            d2 = $urandom;
            ret = $urandom;
            imm = $urandom;
            rdata = $urandom;
            rd = 5'($urandom);
            aw = $urandom_range(0, 3);
            ctrl = 12'($urandom_range(0, 15)) << 8;
            ctrl = ctrl | 12'(regw) | (12'(mr) << 1) | (12'(mw) << 2) |
                   (12'(size) << 3) | (12'(uns) << 5) | (12'(wsel) << 6);
            off = int'(res[1:0]);
            memop = mr | mw;
            mis = memop && ((size == 1 && off % 2 != 0) ||
                            (size == 2 && off != 0));
            aligned = memop && !mis;
            exp_rw = regw && !mis && !(mr && mw);
            exp_cyc = aligned ? 2 + aw : 1;
            case (wsel)
                0: exp_wb = res;
                1: exp_wb = ref_load(rdata, off, size, uns);
                2: exp_wb = ret;
                default: exp_wb = imm;
            endcase
            if (size == 0) begin
                exp_wd = (d2 & 32'hFF) * 32'h0101_0101;
                exp_strb = 4'(1 << off);
            end else if (size == 1) begin
                exp_wd = (d2 & 32'hFFFF) * 32'h0001_0001;
                exp_strb = 4'(3 << (off & 2));
            end else begin
                exp_wd = d2;
                exp_strb = 4'hF;
            end
            run_op(ctrl, rd, res, d2, ret, imm, rdata, aw, o);
            checks++;
            if (o.timeout || o.cycles !== exp_cyc ||
                o.stalls !== exp_cyc - 1 ||
                o.reqs !== (aligned ? exp_cyc - 1 : 0)) begin
                errors++;
                $display("FAIL rnd%0d_timing got cyc=%0d st=%0d rq=%0d want cyc=%0d",
                         n, o.cycles, o.stalls, o.reqs, exp_cyc);
            end
            checks++;
            if (o.rd !== rd || o.rw !== exp_rw || o.mis !== mis ||
                o.req_after !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_wb got rd=%0d rw=%b mis=%b want %0d %b %b",
                         n, o.rd, o.rw, o.mis, rd, exp_rw, mis);
            end
            if (exp_rw && !(wsel == 1 && !aligned)) begin
                checks++;
                if (o.wb !== exp_wb) begin
                    errors++;
                    $display("FAIL rnd%0d_data got %h want %h", n, o.wb, exp_wb);
                end
            end
            if (aligned) begin
                checks++;
                if (o.addr !== (res & ~32'h3) || o.we !== mw || !o.stable ||
                    o.wstrb !== (mw ? exp_strb : 4'h0)) begin
                    errors++;
                    $display("FAIL rnd%0d_req got a=%h we=%b s=%b st=%b want a=%h we=%b",
                             n, o.addr, o.we, o.wstrb, o.stable,
                             res & ~32'h3, mw);
                end
                if (mw) begin
                    checks++;
                    if (o.wdata !== exp_wd) begin
                        errors++;
                        $display("FAIL rnd%0d_wdata got %h want %h",
                                 n, o.wdata, exp_wd);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clkIn);
        #1;
        test_alu();
        test_lw();
        test_lb();
        test_sh();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
